// File: rtl/space_ctrl_pkg.sv
// Shared definitions for the response-path control logic: ASCII constants,
// default baud divisor and the FSM state encodings of the word UART sender.
package space_ctrl_pkg;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  // 100 MHz system clock / 115200 baud
  localparam int CLKS_PER_BIT_DEF = 868;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SEND,
    W_DONE
  } word_state_t;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } byte_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 transmitter for a single character. A start request seen on the last
// cycle of a stop bit chains the next frame with no idle gap on the line.
module uart_tx_byte
  import space_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  tx_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  byte_state_t           state_q, state_d;
  logic [CNT_W-1:0]      baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  baud_last;

  assign baud_last = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= B_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_last ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_o  = 1'b0;

    case (state_q)
      B_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (start_i) begin
          state_d = B_START;
          shift_d = data_i;
          bit_d   = '0;
          tx_d    = 1'b0;
        end
      end
      B_START: begin
        if (baud_last) begin
          state_d = B_DATA;
          tx_d    = shift_q[0];
        end
      end
      B_DATA: begin
        if (baud_last) begin
          if (bit_q == BIT_LAST) begin
            state_d = B_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      B_STOP: begin
        if (baud_last) begin
          done_o = 1'b1;
          if (start_i) begin
            state_d = B_START;
            shift_d = data_i;
            bit_d   = '0;
            tx_d    = 1'b0;
          end else begin
            state_d = B_IDLE;
          end
        end
      end
      default: begin
        state_d = B_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign busy_o = (state_q != B_IDLE);
  assign tx_o   = tx_q;

endmodule

// File: rtl/word_uart_sender.sv
// Sends 1..4 bytes of a response word (LS byte first) as back-to-back 8N1
// frames, triggered by a rising edge of valid_data while idle.
module word_uart_sender
  import space_ctrl_pkg::*;
#(
  parameter int WORD_SIZE    = 32,
  parameter int SIZE_WORD    = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] send_data_register,
  input  logic [SIZE_WORD-1:0] size_line,
  input  logic                 valid_data,
  output logic                 busy_sender_data,
  output logic                 tx,
  output logic                 word_done
);

  localparam int MAX_BYTES = WORD_SIZE / DATA_WIDTH;
  localparam logic [SIZE_WORD-1:0] MAX_SIZE = SIZE_WORD'(MAX_BYTES);

  word_state_t           state_q, state_d;
  logic                  valid_q;
  logic [WORD_SIZE-1:0]  word_q, word_d;
  logic [SIZE_WORD-1:0]  size_q, size_d;
  logic [SIZE_WORD-1:0]  byte_idx_q, byte_idx_d;
  logic [SIZE_WORD-1:0]  byte_idx_inc;
  logic [SIZE_WORD-1:0]  size_clamped;
  logic                  accept;
  logic                  tx_start;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_busy;
  logic                  tx_done;

  assign accept       = (state_q == W_IDLE) && valid_data && !valid_q && !tx_busy;
  assign size_clamped = (size_line > MAX_SIZE) ? MAX_SIZE : size_line;
  assign byte_idx_inc = byte_idx_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= W_IDLE;
      valid_q    <= 1'b0;
      word_q     <= '0;
      size_q     <= '0;
      byte_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_data;
      word_q     <= word_d;
      size_q     <= size_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  // word_q always holds the not-yet-sent bytes with the next one in the low lane,
  // so the first byte comes straight from the input on the accept cycle.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    size_d     = size_q;
    byte_idx_d = byte_idx_q;
    tx_start   = 1'b0;
    tx_data    = word_q[DATA_WIDTH-1:0];

    case (state_q)
      W_IDLE: begin
        if (accept) begin
          size_d     = size_clamped;
          byte_idx_d = '0;
          word_d     = send_data_register >> DATA_WIDTH;
          tx_data    = send_data_register[DATA_WIDTH-1:0];
          if (size_clamped == '0) begin
            state_d = W_DONE;
          end else begin
            tx_start = 1'b1;
            state_d  = W_SEND;
          end
        end
      end
      W_SEND: begin
        if (tx_done) begin
          byte_idx_d = byte_idx_inc;
          if (byte_idx_inc == size_q) begin
            state_d = W_DONE;
          end else begin
            tx_start = 1'b1;
            word_d   = word_q >> DATA_WIDTH;
          end
        end
      end
      W_DONE: begin
        state_d = W_IDLE;
      end
      default: begin
        state_d = W_IDLE;
      end
    endcase
  end

  uart_tx_byte #(
    .DATA_WIDTH  (DATA_WIDTH),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk    (clk),
    .rst    (rst),
    .start_i(tx_start),
    .data_i (tx_data),
    .busy_o (tx_busy),
    .done_o (tx_done),
    .tx_o   (tx)
  );

  assign busy_sender_data = (state_q != W_IDLE);
  assign word_done        = (state_q == W_DONE);

endmodule

// File: tb/tb_word_uart_sender.sv
// Directed bench for word_uart_sender at 4 clk/bit with a line-decoding monitor.
module tb_word_uart_sender;

  localparam int BIT_CLKS   = 4;
  localparam int FRAME_CLKS = 10 * BIT_CLKS;

  logic        clk;
  logic        rst;
  logic [31:0] send_data_register;
  logic [2:0]  size_line;
  logic        valid_data;
  logic        busy_sender_data;
  logic        tx;
  logic        word_done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int pulses_at_start = 0;
  int done_pulses = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_b[4];

  word_uart_sender #(
    .WORD_SIZE   (32),
    .SIZE_WORD   (3),
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(BIT_CLKS)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .send_data_register(send_data_register),
    .size_line         (size_line),
    .valid_data        (valid_data),
    .busy_sender_data  (busy_sender_data),
    .tx                (tx),
    .word_done         (word_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line monitor: decodes frames by sampling every negedge; every sample inside
  // a bit cell must agree, start cell all 0, stop cell all 1.
  initial begin
    bit mon_act;
    int mon_cnt;
    bit mon_bad;
    logic [7:0] mon_byte;
    int bit_n;
    int ph;
    mon_act = 0; mon_cnt = 0; mon_bad = 0; mon_byte = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_act = 0;
      end else if (!mon_act) begin
        if (tx === 1'b0) begin
          mon_act = 1; mon_cnt = 1; mon_bad = 0; mon_byte = '0;
        end
      end else begin
        bit_n = mon_cnt / BIT_CLKS;
        ph    = mon_cnt % BIT_CLKS;
        if (bit_n == 0) begin
          if (tx !== 1'b0) mon_bad = 1;
        end else if (bit_n <= 8) begin
          if (ph == 0) mon_byte[bit_n-1] = tx;
          else if (tx !== mon_byte[bit_n-1]) mon_bad = 1;
        end else begin
          if (tx !== 1'b1) mon_bad = 1;
        end
        if (mon_cnt == FRAME_CLKS - 1) begin
          rx_q.push_back(mon_byte);
          check("frame_shape", {31'd0, mon_bad}, 32'd0);
          mon_act = 0;
        end else begin
          mon_cnt++;
        end
      end
      if (!rst && word_done === 1'b1) done_pulses++;
    end
  end

  // One-cycle valid pulse; returns at the negedge just after the accept edge.
  task automatic start_word(input logic [31:0] w, input logic [2:0] sz, input int n);
    @(negedge clk);
    rx_q.delete();
    pulses_at_start = done_pulses;
    send_data_register = w;
    size_line = sz;
    valid_data = 1'b1;
    @(negedge clk);
    valid_data = 1'b0;
    acc_cyc = cyc;
    check("busy_after_accept", {31'd0, busy_sender_data}, 32'd1);
    check("tx_first_cycle", {31'd0, tx}, (n > 0) ? 32'd0 : 32'd1);
  endtask

  task automatic wait_done(input int n);
    bit found;
    int done_cyc;
    found = 0;
    done_cyc = 0;
    for (int i = 0; i < 1000; i++) begin
      if (word_done === 1'b1) begin
        found = 1;
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", {31'd0, found}, 32'd1);
    if (found) check("done_latency", done_cyc - acc_cyc, n * FRAME_CLKS);
    check("busy_during_done", {31'd0, busy_sender_data}, 32'd1);
    @(negedge clk);
    check("done_one_cycle", {31'd0, word_done}, 32'd0);
    check("busy_after_done", {31'd0, busy_sender_data}, 32'd0);
    check("tx_idle_high", {31'd0, tx}, 32'd1);
    check("done_pulse_count", done_pulses - pulses_at_start, 32'd1);
    check("byte_count", rx_q.size(), n);
    for (int i = 0; i < n; i++)
      check($sformatf("byte%0d", i), (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hFFFF_FFFF,
            {24'd0, exp_b[i]});
  endtask

  initial begin
    rst = 1'b1;
    valid_data = 1'b0;
    send_data_register = '0;
    size_line = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy_sender_data}, 32'd0);
    check("reset_done", {31'd0, word_done}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // "BSY\r", 4 bytes
    exp_b = '{8'h42, 8'h53, 8'h59, 8'h0D};
    start_word(32'h0D595342, 3'd4, 4);
    wait_done(4);

    // Level-held valid: exactly one word
    @(negedge clk);
    rx_q.delete();
    pulses_at_start = done_pulses;
    send_data_register = 32'h0D595342;
    size_line = 3'd4;
    valid_data = 1'b1;
    @(negedge clk);
    check("held_busy", {31'd0, busy_sender_data}, 32'd1);
    repeat (500) @(negedge clk);
    valid_data = 1'b0;
    repeat (5) @(negedge clk);
    check("held_done_pulses", done_pulses - pulses_at_start, 32'd1);
    check("held_byte_count", rx_q.size(), 32'd4);
    check("held_busy_end", {31'd0, busy_sender_data}, 32'd0);
    check("held_byte3", (rx_q.size() == 4) ? {24'd0, rx_q[3]} : 32'hFFFF_FFFF, 32'h0D);

    // Size 2 sends only the two low bytes
    exp_b = '{8'h31, 8'h34, 8'h00, 8'h00};
    start_word(32'h0D0A3431, 3'd2, 2);
    wait_done(2);

    // Size 0: no start bit, done on the next cycle
    start_word(32'h12345678, 3'd0, 0);
    wait_done(0);

    // Second edge mid-byte is dropped
    exp_b = '{8'h55, 8'h00, 8'h00, 8'h00};
    start_word(32'h00000055, 3'd1, 1);
    repeat (10) @(negedge clk);
    send_data_register = 32'h000000AA;
    valid_data = 1'b1;
    @(negedge clk);
    valid_data = 1'b0;
    wait_done(1);
    exp_b = '{8'hAA, 8'h00, 8'h00, 8'h00};
    start_word(32'h000000AA, 3'd1, 1);
    wait_done(1);

    // Reset during bit 3 of byte 1 aborts at once
    start_word(32'h44332211, 3'd4, 4);
    repeat (57) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_tx", {31'd0, tx}, 32'd1);
    check("rst_mid_busy", {31'd0, busy_sender_data}, 32'd0);
    check("rst_mid_done", {31'd0, word_done}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_partial_bytes", rx_q.size(), 32'd1);
    exp_b = '{8'h4F, 8'h4B, 8'h0A, 8'h0D};
    start_word(32'h0D0A4B4F, 3'd4, 4);
    wait_done(4);

    // Size 7 clamps to 4
    exp_b = '{8'hF0, 8'h0F, 8'hC3, 8'hA5};
    start_word(32'hA5C30FF0, 3'd7, 4);
    wait_done(4);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
